// File: rtl/dcache_assoc.sv
// Set-associative write-back data cache between a CPU data bus and a burst memory bus.
// Cached window is 0x8xxx_xxxx; everything else is passed through as single-beat accesses.
package dcache_assoc_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // len carries beats-1
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  localparam logic [2:0] MSIZE8          = 3'd3;
  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
endpackage

module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int          TAG_SIGNED = 28 - int'(OFFSET_BITS) - int'(INDEX_BITS);
  localparam int unsigned TAG_WIDTH  = (TAG_SIGNED < 1) ? 1 : TAG_SIGNED;
  localparam int unsigned WORDS      = 1 << (OFFSET_BITS - 3);
  localparam int unsigned SETS       = 1 << INDEX_BITS;
  localparam int unsigned WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BEAT_BITS  = OFFSET_BITS - 3;

  if (TAG_SIGNED < 1) begin : g_tag_err
    $error("dcache_assoc: tag width must be at least 1");
  end
  if (!(WAYS == 1 || WAYS == 2 || WAYS == 4 || WAYS == 8)) begin : g_ways_err
    $error("dcache_assoc: WAYS must be 1, 2, 4 or 8");
  end
  if (OFFSET_BITS < 4 || OFFSET_BITS > 7) begin : g_off_err
    $error("dcache_assoc: OFFSET_BITS must be 4..7");
  end

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UNCACHED} state_t;

  state_t                 state_q, state_d;
  logic [BEAT_BITS-1:0]   cnt_q, cnt_d;
  logic [WAY_BITS-1:0]    victim_q, victim_d;

  logic                   valid_q [WAYS][SETS];
  logic                   dirty_q [WAYS][SETS];
  logic [TAG_WIDTH-1:0]   tag_q   [WAYS][SETS];
  logic [WAY_BITS-1:0]    ptr_q   [SETS];
  logic [63:0]            data_q  [WAYS][SETS][WORDS];

  logic [INDEX_BITS-1:0]  req_index;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [BEAT_BITS-1:0]   req_word;
  logic                   cached;

  assign req_index = dreq.addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag   = dreq.addr[OFFSET_BITS + INDEX_BITS +: TAG_WIDTH];
  assign req_word  = dreq.addr[3 +: BEAT_BITS];
  assign cached    = (dreq.addr[63:32] == 32'h0) && (dreq.addr[31:28] == 4'h8);

  // Tag lookup and victim choice for the requested set
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic                has_inv;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] victim_sel;
  logic                victim_dirty;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[w][req_index] && (tag_q[w][req_index] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[w][req_index]) begin
        has_inv = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
    victim_sel   = has_inv ? inv_way : ptr_q[req_index];
    victim_dirty = valid_q[victim_sel][req_index] && dirty_q[victim_sel][req_index];
  end

  logic [WAY_BITS-1:0]  ptr_next;
  assign ptr_next = (WAYS == 1) ? '0 : victim_q + WAY_BITS'(1);

  logic                 hit_write;
  logic                 refill_done;
  logic                 mem_we;
  logic [WAY_BITS-1:0]  mem_way;
  logic [BEAT_BITS-1:0] mem_word;
  logic [7:0]           mem_strb;
  logic [63:0]          mem_wdata;

  // Next state, bus outputs and data-store write port
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    victim_d    = victim_q;
    hit_write   = 1'b0;
    refill_done = 1'b0;
    mem_we      = 1'b0;
    mem_way     = hit_way;
    mem_word    = req_word;
    mem_strb    = dreq.strobe;
    mem_wdata   = dreq.data;
    dresp         = '0;
    dresp.addr_ok = 1'b1;
    dresp.data    = data_q[hit_way][req_index][req_word];
    creq        = '0;
    creq.valid  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          if (!cached) begin
            state_d = UNCACHED;
          end else if (hit) begin
            dresp.data_ok = 1'b1;
            if (|dreq.strobe) begin
              mem_we    = 1'b1;
              hit_write = 1'b1;
            end
          end else begin
            victim_d = victim_sel;
            cnt_d    = '0;
            state_d  = victim_dirty ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        creq.is_write = 1'b1;
        creq.size     = MSIZE8;
        creq.addr     = {32'h0, 4'h8, tag_q[victim_q][req_index], req_index,
                         {OFFSET_BITS{1'b0}}};
        creq.strobe   = 8'hff;
        creq.data     = data_q[victim_q][req_index][cnt_q];
        creq.len      = 8'(WORDS - 1);
        creq.burst    = AXI_BURST_INCR;
        if (cresp.ready) begin
          cnt_d = cnt_q + BEAT_BITS'(1);
          if (cresp.last) begin
            cnt_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        creq.size  = MSIZE8;
        creq.addr  = {dreq.addr[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        creq.len   = 8'(WORDS - 1);
        creq.burst = AXI_BURST_INCR;
        if (cresp.ready) begin
          mem_we    = 1'b1;
          mem_way   = victim_q;
          mem_word  = cnt_q;
          mem_strb  = 8'hff;
          mem_wdata = cresp.data;
          cnt_d     = cnt_q + BEAT_BITS'(1);
          if (cresp.last) begin
            cnt_d       = '0;
            refill_done = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      UNCACHED: begin
        creq.is_write = |dreq.strobe;
        creq.size     = dreq.size;
        creq.addr     = dreq.addr;
        creq.strobe   = dreq.strobe;
        creq.data     = dreq.data;
        creq.len      = 8'd0;
        creq.burst    = AXI_BURST_FIXED;
        if (cresp.ready) begin
          dresp.data_ok = 1'b1;
          dresp.data    = cresp.data;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    dresp.data_ok = dresp.data_ok & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      victim_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
  end

  // Valid/dirty bits and round-robin pointers; pointer only moves on refill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        for (int s = 0; s < int'(SETS); s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < int'(SETS); s++) ptr_q[s] <= '0;
    end else begin
      if (hit_write) dirty_q[hit_way][req_index] <= 1'b1;
      if (refill_done) begin
        valid_q[victim_q][req_index] <= 1'b1;
        dirty_q[victim_q][req_index] <= 1'b0;
        ptr_q[req_index]             <= ptr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (refill_done) tag_q[victim_q][req_index] <= req_tag;
  end

  // Byte-strobed data store, untouched by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_strb[b]) data_q[mem_way][req_index][mem_word][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: flat-memory reference model, scoreboard monitor and a burst bus slave.
module tb_dcache_assoc;
  import dcache_assoc_pkg::*;

  localparam int unsigned WAYS = 2, IB = 4, OB = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  longint ok_cyc = 0;
  longint last_beat_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_assoc #(.WAYS(WAYS), .INDEX_BITS(IB), .OFFSET_BITS(OB)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .creq(creq), .cresp(cresp)
  );

  // CPU-visible memory: what every read must return
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] sl_mem  [logic [63:0]];

  function automatic logic [63:0] gen(input logic [63:0] a);
    return (a >> 3) * 64'h9E37_79B9_7F4A_7C15 ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [7:0] s,
                                        input logic [63:0] d);
    logic [63:0] r = o;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] key(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(key(a)) ? ref_mem[key(a)] : gen(key(a));
  endfunction

  function automatic logic [63:0] sl_rd(input logic [63:0] a);
    return sl_mem.exists(key(a)) ? sl_mem[key(a)] : gen(key(a));
  endfunction

  function automatic bit is_cached(input logic [63:0] a);
    return (a[63:32] == 32'h0) && (a[31:28] == 4'h8);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Scoreboard
  typedef struct {
    logic        is_read;
    logic        unc;
    logic [63:0] exp;
  } sb_t;
  sb_t sbq[$];

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (!reset && dresp.data_ok) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_data_ok: got data_ok=1 want 0 (addr %h)", dreq.addr);
        end else begin
          e = sbq.pop_front();
          if (e.is_read) check("read_data", dresp.data, e.exp);
          if (e.unc) check("unc_ok_with_ready", 64'(cresp.ready), 64'd1);
        end
      end
    end
  end

  // Memory-bus slave: records completed transactions
  typedef struct {
    logic            is_write;
    logic [63:0]     addr;
    logic [7:0]      len;
    logic [1:0]      burst;
    int              beats;
    logic [7:0][63:0] wdata;
  } txn_t;
  txn_t bus_log[$];

  int   delay_cfg = -1;
  bit   in_txn = 1'b0;
  int   t_beat = 0;
  int   t_wait = 0;
  txn_t cur;

  function automatic logic [63:0] beat_addr(input txn_t t, input int beat);
    return (t.burst == AXI_BURST_INCR) ? t.addr + 64'(beat * 8) : t.addr;
  endfunction

  initial begin : slave
    cresp = '0;
    forever begin
      @(negedge clk);
      if (reset || !creq.valid) begin
        in_txn = 1'b0;
      end else if (in_txn && cresp.ready) begin
        if (cur.is_write) begin
          sl_mem[key(beat_addr(cur, t_beat))] = merge(sl_rd(beat_addr(cur, t_beat)),
                                                      creq.strobe, creq.data);
          if (t_beat < 8) cur.wdata[t_beat] = creq.data;
        end
        t_beat++;
        t_wait = (delay_cfg >= 0) ? 0 : int'($urandom_range(0, 1));
        if (cresp.last) begin
          cur.beats = t_beat;
          bus_log.push_back(cur);
          last_beat_cyc = cyc;
          in_txn = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      cresp = '0;
      if (!reset && creq.valid) begin
        if (!in_txn) begin
          in_txn       = 1'b1;
          cur.is_write = creq.is_write;
          cur.addr     = creq.addr;
          cur.len      = creq.len;
          cur.burst    = creq.burst;
          cur.beats    = 0;
          cur.wdata    = '0;
          t_beat       = 0;
          t_wait       = (delay_cfg >= 0) ? delay_cfg : int'($urandom_range(0, 2));
        end
        if (t_wait > 0) begin
          t_wait--;
        end else begin
          cresp.ready = 1'b1;
          cresp.last  = (t_beat == int'(cur.len));
          if (!cur.is_write) cresp.data = sl_rd(beat_addr(cur, t_beat));
        end
      end
    end
  end

  // Issue one CPU request; lat = cycles after the issue cycle until data_ok
  task automatic do_req(input logic [63:0] a, input logic [7:0] strb, input logic [63:0] d,
                        output int lat);
    sb_t e;
    e.is_read = (strb == 8'h0);
    e.unc     = !is_cached(a);
    e.exp     = ref_rd(a);
    if (strb != 8'h0) ref_mem[key(a)] = merge(ref_rd(a), strb, d);
    sbq.push_back(e);
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = MSIZE8;
    dreq.strobe = strb;
    dreq.data   = d;
    lat = 0;
    @(negedge clk);
    while (!dresp.data_ok) begin
      lat++;
      if (lat > 300) begin
        total++;
        bad++;
        $display("FAIL req_timeout: got no data_ok want data_ok within 300 cycles (addr %h)", a);
        finish_now();
      end
      @(negedge clk);
    end
    ok_cyc = cyc;
    @(posedge clk);
    #1;
    dreq.valid  = 1'b0;
    dreq.strobe = 8'h0;
  endtask

  task automatic check_txn(input string name, input int i, input logic wr,
                           input logic [63:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input int beats);
    if (bus_log.size() > i) begin
      check({name, "_is_write"}, 64'(bus_log[i].is_write), 64'(wr));
      check({name, "_addr"}, bus_log[i].addr, a);
      check({name, "_len"}, 64'(bus_log[i].len), 64'(len));
      check({name, "_burst"}, 64'(bus_log[i].burst), 64'(burst));
      check({name, "_beats"}, 64'(bus_log[i].beats), 64'(beats));
    end
  endtask

  initial begin : main
    int lat;
    int n;
    logic [63:0] a;
    logic [7:0]  s;
    dreq = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_creq_valid", 64'(creq.valid), 64'd0);
    check("reset_data_ok", 64'(dresp.data_ok), 64'd0);
    check("addr_ok_tied", 64'(dresp.addr_ok), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Cold read: one 4-beat fetch, data_ok the cycle after the last beat
    bus_log.delete();
    do_req(64'h8000_0040, 8'h00, 64'h0, lat);
    check("cold_txn_count", 64'(bus_log.size()), 64'd1);
    check_txn("cold_fetch", 0, 1'b0, 64'h8000_0040, 8'd3, AXI_BURST_INCR, 4);
    check("cold_ok_after_last", 64'(ok_cyc - last_beat_cyc), 64'd1);

    // Write hit and readback, both same-cycle
    bus_log.delete();
    do_req(64'h8000_0048, 8'hff, 64'h1122_3344_5566_7788, lat);
    check("write_hit_lat", 64'(lat), 64'd0);
    do_req(64'h8000_0048, 8'h00, 64'h0, lat);
    check("readback_lat", 64'(lat), 64'd0);
    check("readback_ref", ref_rd(64'h8000_0048), 64'h1122_3344_5566_7788);
    check("hit_no_bus", 64'(bus_log.size()), 64'd0);

    // Fill set 2 with B, then C evicts dirty A
    bus_log.delete();
    do_req(64'h8000_0240, 8'h00, 64'h0, lat);
    check("fill_b_txn_count", 64'(bus_log.size()), 64'd1);
    bus_log.delete();
    do_req(64'h8000_0440, 8'h00, 64'h0, lat);
    check("evict_txn_count", 64'(bus_log.size()), 64'd2);
    check_txn("writeback", 0, 1'b1, 64'h8000_0040, 8'd3, AXI_BURST_INCR, 4);
    if (bus_log.size() > 0)
      for (int i = 0; i < 4; i++)
        check($sformatf("wb_beat%0d", i), bus_log[0].wdata[i], ref_rd(64'h8000_0040 + 64'(8 * i)));
    check_txn("fetch_c", 1, 1'b0, 64'h8000_0440, 8'd3, AXI_BURST_INCR, 4);
    bus_log.delete();
    do_req(64'h8000_0258, 8'h00, 64'h0, lat);
    check("b_still_hits", 64'(lat), 64'd0);
    check("b_hit_no_bus", 64'(bus_log.size()), 64'd0);

    // Uncached read with ready held off for 3 cycles
    bus_log.delete();
    delay_cfg = 3;
    do_req(64'h1000_0000, 8'h00, 64'h0, lat);
    delay_cfg = -1;
    check("unc_lat", 64'(lat), 64'd4);
    check("unc_txn_count", 64'(bus_log.size()), 64'd1);
    check_txn("unc", 0, 1'b0, 64'h1000_0000, 8'd0, AXI_BURST_FIXED, 1);
    do_req(64'h8000_0448, 8'h00, 64'h0, lat);
    check("unc_c_hits", 64'(lat), 64'd0);
    do_req(64'h8000_0248, 8'h00, 64'h0, lat);
    check("unc_b_hits", 64'(lat), 64'd0);
    check("unc_meta_no_bus", 64'(bus_log.size()), 64'd1);

    // Reset on beat 2 of a fetch
    bus_log.delete();
    delay_cfg   = 0;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0100;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'h00;
    n = 0;
    @(negedge clk);
    while (!(in_txn && t_beat == 2)) begin
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL reset_wait: got no beat 2 want beat 2 within 50 cycles");
        finish_now();
      end
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    dreq.valid = 1'b0;
    #1;
    check("rst_creq_valid_drop", 64'(creq.valid), 64'd0);
    check("rst_data_ok", 64'(dresp.data_ok), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_burst_abandoned", 64'(bus_log.size()), 64'd0);
    @(posedge clk);
    #1;
    do_req(64'h8000_0100, 8'h00, 64'h0, lat);
    check("rst_refetch_lat", 64'(lat), 64'd5);
    check("rst_refetch_count", 64'(bus_log.size()), 64'd1);
    check_txn("rst_refetch", 0, 1'b0, 64'h8000_0100, 8'd3, AXI_BURST_INCR, 4);
    delay_cfg = -1;

    // Random mix of hits, misses, evictions and uncached accesses
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0)
        a = 64'h1000_0000 + 64'($urandom_range(0, 7) << 3);
      else
        a = 64'h8000_0000 | 64'($urandom_range(0, 5) << 9) | 64'($urandom_range(0, 3) << 5)
            | 64'($urandom_range(0, 3) << 3);
      s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      do_req(a, s, {$urandom, $urandom}, lat);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", 64'(sbq.size()), 64'd0);
    finish_now();
  end

endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter INDEX_BITS, default 6, set index width; sets = 2^INDEX_BITS.
REQ-003 SHALL have parameter OFFSET_BITS, default 6, line byte offset width; legal 4..7; WORDS = 2^(OFFSET_BITS-3) 64-bit beats per line.
REQ-004 SHALL derive TAG_WIDTH = 28-OFFSET_BITS-INDEX_BITS; TAG_WIDTH < 1 is an elaboration error.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 dreq  input  dbus_req_t  CPU data request (valid, addr, size, strobe, data).
REQ-008 dresp  output  dbus_resp_t  CPU response (addr_ok, data_ok, data).
REQ-009 creq  output  cbus_req_t  memory bus request (valid, is_write, size, addr, strobe, data, len, burst).
REQ-010 cresp  input  cbus_resp_t  memory bus response (ready, last, data).

Function
REQ-011 Cached range: addr[63:32]==0 and addr[31:28]==4'h8; all other addresses are uncached.
REQ-012 Address split: offset = addr[OFFSET_BITS-1:0], index = next INDEX_BITS, tag = next TAG_WIDTH.
REQ-013 Per set, per way metadata (valid, dirty, tag) SHALL be held in flops; per set a replacement pointer of log2(WAYS) bits (0 bits if WAYS=1).
REQ-014 Data store SHALL be byte-strobed, WAYS*2^INDEX_BITS*WORDS x 64 bits, zero-latency read.
REQ-015 States: IDLE, WRITEBACK, FETCH, UNCACHED.
REQ-016 IDLE, dreq.valid, uncached -> UNCACHED.
REQ-017 IDLE, dreq.valid, cached hit (valid and tag match in any way) -> data_ok=1 same cycle, data = hit word; nonzero strobe writes bytes and sets that way's dirty bit at the edge; stay IDLE.
REQ-018 IDLE, cached miss -> select victim: lowest-numbered invalid way, else way at replacement pointer; victim valid and dirty -> WRITEBACK, otherwise -> FETCH.
REQ-019 Victim way SHALL be latched on leaving IDLE and held until return to IDLE.
REQ-020 WRITEBACK: creq write, addr = {32'h0, 4'h8, victim tag, index, OFFSET_BITS'0}, size MSIZE8, strobe all ones, len = WORDS beats, burst INCR, data = victim word[beat counter]; counter increments on cresp.ready; on ready&last -> FETCH, counter cleared.
REQ-021 FETCH: creq read, addr = line base of dreq.addr, same size/len/burst; each ready beat writes cresp.data to victim word[counter]; on ready&last: victim valid=1, dirty=0, tag=request tag, pointer = victim+1 mod WAYS, counter cleared -> IDLE.
REQ-022 After FETCH the request SHALL be re-evaluated in IDLE as a hit (miss costs one extra cycle beyond the bursts); a write miss is merged on that hit cycle.
REQ-023 UNCACHED: creq passes dreq addr/size/strobe/data, len 1 beat, burst FIXED, is_write = |strobe; on cresp.ready -> data_ok=1, data = cresp.data, -> IDLE.
REQ-024 data_ok SHALL be asserted only in REQ-017 and REQ-023 cases; never in WRITEBACK or FETCH.
REQ-025 creq.valid = (state != IDLE); addr_ok tied 1.
REQ-026 CPU SHALL hold dreq stable from valid until data_ok; the block does not buffer requests.
REQ-027 Hit cycles SHALL NOT update the replacement pointer (refill-order round robin).
REQ-028 Multiple-way tag match cannot occur; behaviour undefined if forced.

Reset
REQ-029 reset=1 SHALL immediately (asynchronously) force state IDLE, counter 0, all valid/dirty bits 0, all pointers 0; data store contents unchanged.
REQ-030 During reset: creq.valid=0, dresp.data_ok=0; reset mid-burst abandons the burst without further beats.

Verification
REQ-031 WAYS=2, INDEX_BITS=4, OFFSET_BITS=5: read 0x8000_0040 cold -> FETCH 4 beats at 0x8000_0040, no WRITEBACK, data_ok one cycle after last with beat 0 data.
REQ-032 Write 0x8000_0048 strobe 0xFF data 0x1122334455667788 after REQ-031 -> same-cycle data_ok; readback returns 0x1122334455667788.
REQ-033 Fill set 2 with tags A, B, then miss tag C -> way 0 (tag A, dirty from prior write) written back at A line base with 4 beats in order, then FETCH of C; tag B still hits.
REQ-034 Read 0x1000_0000 (uncached) with cresp.ready delayed 3 cycles -> single-beat FIXED read, data_ok only on ready cycle, cache metadata unchanged.
REQ-035 Assert reset on beat 2 of a FETCH -> creq.valid falls in same cycle, next read of that line misses and refetches.
